// File: rtl/duty_ui_pkg.sv
// Shared defaults for the duty-cycle button front end. The PWM top-level
// wrapper uses the same constants, so both blocks stay in step.
package duty_ui_pkg;

    localparam int DUTY_SYNC_STAGES     = 2;   // synchronizer depth (min 2)
    localparam int DUTY_DEBOUNCE_CYCLES = 4;   // stable cycles before a level flip (min 1)
    localparam int DUTY_REPEAT_DELAY    = 16;  // press pulse to first repeat; 0 = no repeat
    localparam int DUTY_REPEAT_PERIOD   = 8;   // cycles between repeats (min 1)
    localparam int DUTY_CNT_W           = 8;   // counter width

endpackage

// File: rtl/debounce_channel.sv
// One button channel: a synchronizer chain followed by a debounce counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_raw          : raw asynchronous button level
//   o_level_d      : next debounced level (from flops only; lets the parent
//                    register edge pulses in the same cycle the level flips)
//   o_level_q      : registered debounced level
module debounce_channel
    import duty_ui_pkg::*;
#(
    parameter int SYNC_STAGES     = DUTY_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DUTY_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DUTY_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level_d,
    output logic o_level_q
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   synced;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_raw};
        synced  = sync_q[SYNC_STAGES-1];
        level_d = level_q;
        cnt_d   = '0;
        if (synced != level_q) begin
            // Flip on the cycle the count would reach DEBOUNCE_CYCLES.
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level_d = level_d;
    assign o_level_q = level_q;

endmodule

// File: rtl/duty_button_cond.sv
// Button conditioning for the PWM duty-cycle block: debounces the increase
// and decrease buttons and produces single-cycle command pulses with
// hold-to-repeat. All outputs are registered.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_increase_duty  : raw increase button (async, active-high)
//   i_decrease_duty  : raw decrease button (async, active-high)
//   o_inc_pulse      : one-cycle increase command
//   o_dec_pulse      : one-cycle decrease command
//   o_inc_level      : debounced increase level
//   o_dec_level      : debounced decrease level
module duty_button_cond
    import duty_ui_pkg::*;
#(
    parameter int SYNC_STAGES     = DUTY_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DUTY_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DUTY_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DUTY_REPEAT_PERIOD,
    parameter int CNT_W           = DUTY_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_increase_duty,
    input  logic i_decrease_duty,
    output logic o_inc_pulse,
    output logic o_dec_pulse,
    output logic o_inc_level,
    output logic o_dec_level
);

    // Index 0 = increase channel, index 1 = decrease channel.
    logic [1:0]       lvl_d, lvl_q, lvl_oth;
    logic [1:0]       rise, press, rep;
    logic [1:0]       inval_q, inval_d;
    logic [1:0]       pulse_q, pulse_d;
    logic [CNT_W-1:0] rep_cnt_q [2];
    logic [CNT_W-1:0] rep_cnt_d [2];

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_inc (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_raw     (i_increase_duty),
        .o_level_d (lvl_d[0]),
        .o_level_q (lvl_q[0])
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dec (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_raw     (i_decrease_duty),
        .o_level_d (lvl_d[1]),
        .o_level_q (lvl_q[1])
    );

    assign lvl_oth = {lvl_d[0], lvl_d[1]};

    always_comb begin
        rise    = '0;
        press   = '0;
        rep     = '0;
        inval_d = '0;
        pulse_d = '0;
        for (int c = 0; c < 2; c++) begin
            rep_cnt_d[c] = rep_cnt_q[c];
            rise[c]  = lvl_d[c] & ~lvl_q[c];
            press[c] = rise[c] & ~lvl_oth[c];
            // A channel that is ever held together with the other one stays
            // invalid until its own release. This covers the earlier-held
            // button, the late arrival and same-cycle rises alike, so no
            // repeat can appear when only one of the two is let go.
            inval_d[c] = lvl_d[c] & (inval_q[c] | lvl_oth[c]);
            // Repeat timer: 0 = idle, otherwise counts down to a pulse at 1.
            if (press[c]) begin
                rep_cnt_d[c] = CNT_W'(REPEAT_DELAY);
            end else if (!lvl_d[c] || inval_d[c]) begin
                rep_cnt_d[c] = '0;
            end else if (rep_cnt_q[c] == CNT_W'(1)) begin
                rep[c]       = 1'b1;
                rep_cnt_d[c] = CNT_W'(REPEAT_PERIOD);
            end else if (rep_cnt_q[c] != '0) begin
                rep_cnt_d[c] = rep_cnt_q[c] - 1'b1;
            end
            pulse_d[c] = press[c] | rep[c];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inval_q      <= '0;
            pulse_q      <= '0;
            rep_cnt_q[0] <= '0;
            rep_cnt_q[1] <= '0;
        end else begin
            inval_q      <= inval_d;
            pulse_q      <= pulse_d;
            rep_cnt_q[0] <= rep_cnt_d[0];
            rep_cnt_q[1] <= rep_cnt_d[1];
        end
    end

    assign o_inc_pulse = pulse_q[0];
    assign o_dec_pulse = pulse_q[1];
    assign o_inc_level = lvl_q[0];
    assign o_dec_level = lvl_q[1];

endmodule

// File: tb/tb_duty_button_cond.sv
// Directed bench for duty_button_cond. Edge numbering: edge 1 is the first
// rising clock edge that samples the scenario's first input vector.
module tb_duty_button_cond;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_increase_duty;
    logic i_decrease_duty;
    logic o_inc_pulse;
    logic o_dec_pulse;
    logic o_inc_level;
    logic o_dec_level;

    int n_assert = 0;
    int n_fail   = 0;
    int e        = 0;

    duty_button_cond dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_increase_duty (i_increase_duty),
        .i_decrease_duty (i_decrease_duty),
        .o_inc_pulse     (o_inc_pulse),
        .o_dec_pulse     (o_dec_pulse),
        .o_inc_level     (o_inc_level),
        .o_dec_level     (o_dec_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    // Drive a vector on the falling edge, then sample 1 time unit after the
    // next rising edge.
    task automatic tick(input logic inc_v, input logic dec_v, input logic rst_v);
        @(negedge i_clk);
        i_rst_n         = rst_v;
        i_increase_duty = inc_v;
        i_decrease_duty = dec_v;
        @(posedge i_clk);
        #1;
        e++;
    endtask

    task automatic check_all(input logic ip, input logic dp, input logic il, input logic dl);
        chk("inc_pulse", o_inc_pulse, ip);
        chk("dec_pulse", o_dec_pulse, dp);
        chk("inc_level", o_inc_level, il);
        chk("dec_level", o_dec_level, dl);
        chk("pulse_excl", o_inc_pulse & o_dec_pulse, 1'b0);
    endtask

    task automatic reset_dut();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        e = 0;
    endtask

    initial begin
        i_rst_n         = 1'b0;
        i_increase_duty = 1'b0;
        i_decrease_duty = 1'b0;

        // 1. Clean press: inc high edges 1..10 -> pulse at 6, level 6..15.
        reset_dut();
        for (int k = 1; k <= 24; k++) begin
            tick(k <= 10, 1'b0, 1'b1);
            check_all(e == 6, 1'b0, (e >= 6 && e <= 15), 1'b0);
        end

        // 2. Bounce: dec toggles every 2 cycles over edges 1..12, steady high
        //    from edge 13 to 24 -> single pulse at 18, level 18..29.
        reset_dut();
        for (int k = 1; k <= 36; k++) begin
            tick(1'b0, (k <= 12) ? (((k - 1) / 2) % 2 == 0) : (k <= 24), 1'b1);
            check_all(1'b0, e == 18, 1'b0, (e >= 18 && e <= 29));
        end

        // 3. Auto-repeat: inc held edges 1..40 -> pulses 6, 22, 30, 38.
        reset_dut();
        for (int k = 1; k <= 52; k++) begin
            tick(k <= 40, 1'b0, 1'b1);
            check_all((e == 6 || e == 22 || e == 30 || e == 38), 1'b0,
                      (e >= 6 && e <= 45), 1'b0);
        end

        // 4. Overlap: inc held 1..40; dec raw high 15..40 so its debounced
        //    level rises at edge 20. Only the inc press pulse at 6.
        reset_dut();
        for (int k = 1; k <= 52; k++) begin
            tick(k <= 40, (k >= 15 && k <= 40), 1'b1);
            check_all(e == 6, 1'b0, (e >= 6 && e <= 45), (e >= 20 && e <= 45));
        end

        // 5. Glitch: inc held 1..40 with a 2-cycle low at edges 15,16.
        reset_dut();
        for (int k = 1; k <= 52; k++) begin
            tick((k <= 40) && !(k == 15 || k == 16), 1'b0, 1'b1);
            check_all((e == 6 || e == 22 || e == 30 || e == 38), 1'b0,
                      (e >= 6 && e <= 45), 1'b0);
        end

        // 6. Reset mid-hold: reset asserted right after edge 25, released
        //    before edge 29 with inc still high -> new press pulse at 34.
        reset_dut();
        for (int k = 1; k <= 44; k++) begin
            tick(1'b1, 1'b0, !(k >= 26 && k <= 28));
            check_all((e == 6 || e == 22 || e == 34), 1'b0,
                      ((e >= 6 && e <= 25) || e >= 34), 1'b0);
        end

        // 7. Simultaneous press: both raw high 1..20, inc alone to 40.
        //    Neither pulses, and inc stays silent after dec is released.
        reset_dut();
        for (int k = 1; k <= 52; k++) begin
            tick(k <= 40, k <= 20, 1'b1);
            check_all(1'b0, 1'b0, (e >= 6 && e <= 45), (e >= 6 && e <= 25));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/duty_button_cond.md
Name: duty_button_cond

Overview:
Upstream input-conditioning stage for the PWM duty-cycle block. It takes the raw, asynchronous, bouncy "increase duty" and "decrease duty" push-buttons and turns them into clean single-cycle command pulses, with hold-to-repeat. Its pulse outputs drive the PWM block's increase/decrease inputs directly. It runs on the same clock as the PWM block.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per button input (min 2)
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized level must differ from the debounced state before the debounced state flips (min 1)
REPEAT_DELAY, 16, cycles from the press pulse to the first auto-repeat pulse; 0 disables auto-repeat
REPEAT_PERIOD, 8, cycles between subsequent auto-repeat pulses (min 1)
CNT_W, 8, width of internal debounce/repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_increase_duty  input  1  raw increase button, asynchronous, active-high
i_decrease_duty  input  1  raw decrease button, asynchronous, active-high
o_inc_pulse  output  1  one-cycle increase command
o_dec_pulse  output  1  one-cycle decrease command
o_inc_level  output  1  debounced increase button level
o_dec_level  output  1  debounced decrease button level

Behaviour:
- Reset (i_rst_n low, asynchronous): all outputs 0; sync chains, debounced states, counters and the hold-invalid flags cleared. Release of reset is synchronous to i_clk in the surrounding design.
- All outputs are registered. There is no combinational path from input to output.
- Per channel:
  - Synchronizer: SYNC_STAGES flops.
  - Debounce counter: increments each cycle the synced level != debounced state. It clears on any cycle they are equal.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
- Latency: edge 1 is the first edge that samples a stable raw high. The debounced level and the press pulse are both visible after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults). Release has the same latency on the level output.
- Press pulse: asserted for exactly 1 cycle on a debounced 0->1 transition, only if the other channel's debounced level is 0.
- Auto-repeat (REPEAT_DELAY>0): while exactly one channel is held and not invalidated:
  - first repeat pulse REPEAT_DELAY cycles after the press pulse;
  - then one pulse every REPEAT_PERIOD cycles.
  - The repeat counter resets on release.
- Simultaneous / overlapping presses:
  - If both debounced levels are 1, both pulse outputs are 0.
  - Any channel that was held when the other rose is marked hold-invalid. It produces no repeats until its own release.
  - Releasing one button never generates a pulse on the other.
  - If both debounced levels rise in the same cycle, neither pulses.
- o_inc_pulse and o_dec_pulse are never high in the same cycle.
- Glitches shorter than DEBOUNCE_CYCLES, in either direction, are ignored. Repeat timing continues through them.
- Reset mid-hold: outputs drop to 0 immediately. After release, a still-held button is treated as a new press (pulse after 6 edges).

Decomposition:
- Package duty_ui_pkg: default constants for SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD and CNT_W, shared with the PWM top-level wrapper.
- Sub-module debounce_channel (synchronizer + debounce counter + level output), instantiated twice.
- Edge detection, mutual exclusion, hold-invalid flags and repeat timers live in duty_button_cond.

Test Plan:
1. Clean press: i_increase_duty high for 10 cycles from edge 1 -> o_inc_pulse high only after edge 6; o_inc_level high from edge 6 to 10 edges after release begins +6; o_dec_pulse stays 0.
2. Bounce: i_decrease_duty toggles every 2 cycles for 12 cycles, then stays high -> exactly one o_dec_pulse, 6 edges after the final rise.
3. Auto-repeat: i_increase_duty held 40 cycles -> o_inc_pulse after edges 6, 22, 30, 38 only (4 pulses).
4. Overlap: increase held from edge 1; decrease rises at edge 20 and is held to edge 40; both then released -> inc pulse at edge 6 only, no pulse at 22. Dec pulse suppressed. No pulses after releases.
5. Glitch: during a 40-cycle increase hold, a 2-cycle low at edge 15 -> o_inc_level stays 1; pulse times identical to scenario 3.
6. Reset mid-hold: assert i_rst_n low at edge 25 of an increase hold, release at edge 28 with input still high -> all outputs 0 from reset assertion; next o_inc_pulse after edge 34.
